// File: rtl/lisnoc_dma_request_dispatcher.sv
// Round-robin consumer of the DMA request table. It issues one request at a
// time to the initiator, waits for its completion, then signals done to the table.
`ifndef DMA_REQUEST_WIDTH
`define DMA_REQUEST_WIDTH 32
`endif

module lisnoc_dma_request_dispatcher #(
    parameter int table_entries = 4,
    localparam int table_entries_ptrwidth = $clog2(table_entries)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [table_entries-1:0]          valid,
    output logic [table_entries_ptrwidth-1:0] ctrl_read_pos,
    input  logic [`DMA_REQUEST_WIDTH-1:0]     ctrl_read_req,
    output logic [table_entries_ptrwidth-1:0] ctrl_done_pos,
    output logic                              ctrl_done_en,
    output logic [`DMA_REQUEST_WIDTH-1:0]     out_req,
    output logic [table_entries_ptrwidth-1:0] out_id,
    output logic                              out_req_valid,
    input  logic                              out_req_ready,
    input  logic                              cpl_valid,
    output logic                              busy
);

    typedef logic [table_entries_ptrwidth-1:0] ptr_t;
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

    state_t state, state_nxt;
    ptr_t   rr_ptr;
    ptr_t   sel;
    ptr_t   cand;
    logic   sel_found;

    // Scan downward over the offsets so the smallest offset from rr_ptr wins.
    always_comb begin
        sel       = rr_ptr;
        cand      = rr_ptr;
        sel_found = 1'b0;
        for (int i = table_entries - 1; i >= 0; i--) begin
            cand = ptr_t'((int'(rr_ptr) + i) % table_entries);
            if (valid[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && sel_found) state_nxt = LOAD;
            LOAD:    state_nxt = ISSUE;
            ISSUE:   if (out_req_ready) state_nxt = cpl_valid ? DONE : WAIT;
            WAIT:    if (cpl_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            ctrl_read_pos <= '0;
            out_id        <= '0;
            out_req       <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == LOAD) begin
                ctrl_read_pos <= sel;
                out_id        <= sel;
            end
            if (state == LOAD)
                out_req <= ctrl_read_req;
            // The table clears the finished entry at this same edge, so the
            // next IDLE scan already sees it gone.
            if (state == DONE)
                rr_ptr <= ptr_t'((int'(out_id) + 1) % table_entries);
        end
    end

    assign out_req_valid = (state == ISSUE);
    assign ctrl_done_en  = (state == DONE);
    assign ctrl_done_pos = out_id;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_lisnoc_dma_request_dispatcher.sv
// Scoreboard bench: a round-robin table model predicts dispatch order and data;
// a monitor checks issues and done strobes against that prediction.
`ifndef DMA_REQUEST_WIDTH
`define DMA_REQUEST_WIDTH 32
`endif

module tb_lisnoc_dma_request_dispatcher;
    localparam int W = `DMA_REQUEST_WIDTH;
    localparam int N = 4;

    typedef struct {
        int           id;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] tv = '0;
    logic [1:0]   ctrl_read_pos, ctrl_done_pos, out_id;
    logic [W-1:0] ctrl_read_req, out_req;
    logic         ctrl_done_en, out_req_valid, busy;
    logic         out_req_ready = 1'b0;
    logic         cpl_valid = 1'b0;

    logic [W-1:0] tbl [N];
    logic [N-1:0] sw_set = '0, sw_clr = '0;
    logic [N-1:0] mv = '0;
    int           m_rr = 0;
    exp_t         exp_q[$];
    int           inflight[$];

    int ready_pct = 100, cpl_min = 0, cpl_max = 0, kick = 0;
    logic manual_cpl = 1'b0;
    int errors = 0, checks = 0;

    assign ctrl_read_req = tbl[ctrl_read_pos];

    lisnoc_dma_request_dispatcher #(.table_entries(N)) dut (
        .clk(clk), .rst(rst), .enable(enable), .valid(tv),
        .ctrl_read_pos(ctrl_read_pos), .ctrl_read_req(ctrl_read_req),
        .ctrl_done_pos(ctrl_done_pos), .ctrl_done_en(ctrl_done_en),
        .out_req(out_req), .out_id(out_id), .out_req_valid(out_req_valid),
        .out_req_ready(out_req_ready), .cpl_valid(cpl_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Reference: drain up to n entries from the model bitmap in round-robin order.
    task automatic plan(input int n);
        for (int k = 0; k < n; k++) begin
            int id;
            id = -1;
            for (int i = 0; i < N; i++)
                if (id < 0 && mv[(m_rr + i) % N]) id = (m_rr + i) % N;
            if (id < 0) break;
            exp_q.push_back('{id, tbl[id]});
            mv[id] = 1'b0;
            m_rr   = (id + 1) % N;
        end
    endtask

    task automatic add_entries(input logic [N-1:0] bits);
        for (int i = 0; i < N; i++)
            if (bits[i]) tbl[i] = {$urandom, $urandom};
        mv     = mv | bits;
        sw_set = bits;
        step();
        sw_set = '0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || inflight.size() != 0 || busy) && n < 400) begin
            step();
            n++;
        end
        check({name, "_drain_timeout"}, 64'(n >= 400), 64'd0);
    endtask

    // Request table: software set/clear plus done clears the entry.
    initial forever begin
        @(negedge clk);
        tv = (tv | sw_set) & ~sw_clr;
        if (ctrl_done_en) tv[ctrl_done_pos] = 1'b0;
    end

    // Initiator: random ready, completion after a random or manual delay.
    initial begin
        int cpl_cnt, last_kick, d;
        cpl_cnt = 0;
        last_kick = 0;
        forever begin
            @(negedge clk);
            cpl_valid = 1'b0;
            if (!rst) begin
                cpl_cnt = 0;
                last_kick = kick;
                out_req_ready = 1'b0;
            end else begin
                if (kick != last_kick) begin
                    last_kick = kick;
                    cpl_valid = 1'b1;
                end
                if (cpl_cnt > 0) begin
                    cpl_cnt--;
                    if (cpl_cnt == 0) cpl_valid = 1'b1;
                end
                out_req_ready = ($urandom_range(0, 99) < ready_pct);
                if (out_req_valid && out_req_ready && !manual_cpl) begin
                    d = $urandom_range(cpl_min, cpl_max);
                    if (d == 0) cpl_valid = 1'b1;
                    else cpl_cnt = d;
                end
            end
        end
    end

    // Monitor
    initial begin
        logic         hold;
        logic [W-1:0] hold_req;
        logic [1:0]   hold_id;
        exp_t         e;
        hold = 1'b0;
        hold_req = '0;
        hold_id = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                inflight.delete();
                hold = 1'b0;
            end else begin
                if (hold && out_req_valid) begin
                    check("hold_req", 64'(out_req), 64'(hold_req));
                    check("hold_id", 64'(out_id), 64'(hold_id));
                end
                hold = 1'b0;
                if (out_req_valid && out_req_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: got id %0d expected none", out_id);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_id", 64'(out_id), 64'(e.id));
                        check("issue_req", 64'(out_req), 64'(e.data));
                        inflight.push_back(e.id);
                    end
                end else if (out_req_valid) begin
                    hold = 1'b1;
                    hold_req = out_req;
                    hold_id = out_id;
                end
                if (ctrl_done_en) begin
                    if (inflight.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got pos %0d expected none", ctrl_done_pos);
                    end else
                        check("done_pos", 64'(ctrl_done_pos), 64'(inflight.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc[$];
        int cyc;
        for (int i = 0; i < N; i++) tbl[i] = '0;

        // reset state
        #2;
        check("reset_outs", 64'({ctrl_read_pos, ctrl_done_pos, ctrl_done_en, out_req, out_id, out_req_valid, busy}), 64'd0);
        step();
        step();
        rst = 1'b1;
        check("post_reset_busy", 64'(busy), 64'd0);

        // fairness: all valid, instant ready and completion
        ready_pct = 100; cpl_min = 0; cpl_max = 0; manual_cpl = 1'b0;
        add_entries(4'b1111);
        plan(4);
        enable = 1'b1;
        cyc = 0;
        while (dc.size() < 4 && cyc < 60) begin
            step();
            cyc++;
            if (ctrl_done_en) dc.push_back(cyc);
        end
        check("fair_dones", 64'(dc.size()), 64'd4);
        for (int i = 1; i < dc.size(); i++) check("fair_gap", 64'(dc[i] - dc[i-1]), 64'd4);
        wait_drain("fair");

        // single entry latency
        manual_cpl = 1'b1;
        tbl[2] = '0;
        mv[2] = 1'b1;
        tbl[2] = W'(64'hA5A5_A5A5_A5A5_A5A5);
        sw_set = 4'b0100;
        plan(1);
        step();
        sw_set = '0;
        step();
        check("lat_read_pos", 64'(ctrl_read_pos), 64'd2);
        check("lat_not_valid_yet", 64'(out_req_valid), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        step();
        check("lat_valid", 64'(out_req_valid), 64'd1);
        check("lat_req", 64'(out_req), 64'(tbl[2]));
        check("lat_id", 64'(out_id), 64'd2);
        step(); step(); step();
        kick++;
        step();
        check("lat_done_early", 64'(ctrl_done_en), 64'd0);
        step();
        check("lat_done_en", 64'(ctrl_done_en), 64'd1);
        check("lat_done_pos", 64'(ctrl_done_pos), 64'd2);
        step();
        check("lat_done_once", 64'(ctrl_done_en), 64'd0);
        check("lat_idle", 64'(busy), 64'd0);

        // ready held low while the table word changes underneath
        manual_cpl = 1'b0; cpl_min = 1; cpl_max = 3; ready_pct = 0;
        add_entries(4'b1000);
        plan(1);
        cyc = 0;
        while (!out_req_valid && cyc < 10) begin
            step();
            cyc++;
        end
        check("stall_reached_issue", 64'(out_req_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tbl[3] = {$urandom, $urandom};
            step();
        end
        ready_pct = 100;
        wait_drain("stall");

        // enable gating
        enable = 1'b0;
        manual_cpl = 1'b1;
        add_entries(4'b0011);
        for (int i = 0; i < 5; i++) begin
            step();
            check("disabled_idle", 64'(busy), 64'd0);
        end
        plan(1);
        enable = 1'b1;
        step(); step(); step();
        enable = 1'b0;
        kick++;
        wait_drain("en_drop");
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_redispatch", 64'(busy), 64'd0);
        end

        // async reset while waiting on entry 1
        plan(1);
        enable = 1'b1;
        step(); step(); step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_outs", 64'({ctrl_read_pos, ctrl_done_pos, ctrl_done_en, out_req, out_id, out_req_valid, busy}), 64'd0);
        step();
        rst = 1'b1;
        mv[1] = 1'b1;
        m_rr = 0;
        plan(1);
        manual_cpl = 1'b0;
        wait_drain("rst_redo");

        // completion while idle, invalidation while waiting
        manual_cpl = 1'b1;
        kick++;
        step(); step();
        check("idle_cpl_ignored", 64'(busy), 64'd0);
        add_entries(4'b1000);
        plan(1);
        step(); step(); step();
        sw_clr = 4'b1000;
        step();
        sw_clr = '0;
        check("inval_still_busy", 64'(busy), 64'd1);
        kick++;
        wait_drain("inval");

        // randomized episodes
        manual_cpl = 1'b0; cpl_min = 0; cpl_max = 4;
        for (int ep = 0; ep < 30; ep++) begin
            enable = 1'b0;
            ready_pct = $urandom_range(20, 100);
            add_entries(4'($urandom_range(1, 15)));
            plan(N);
            enable = 1'b1;
            wait_drain("rand");
        end
        check("model_empty", 64'(mv), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lisnoc_dma_request_dispatcher.md
Name: lisnoc_dma_request_dispatcher

Overview:
Control-side consumer of the DMA request table. It scans the table's per-entry valid bits round-robin and reads the selected request over the control read port. It hands the request to the DMA initiator through a valid/ready handshake, waits for that transfer's completion, then reports done back to the table. Exactly one transfer is outstanding at a time.

Parameters:
table_entries, 4, number of request table entries.
table_entries_ptrwidth, 2, local parameter: entry index width (fixed at 2 for table_entries=4).

Ports:
clk  input  1  clock.
rst  input  1  asynchronous, active-low reset.
enable  input  1  when high, new dispatches are allowed; an in-flight transfer always completes.
valid  input  table_entries  table entries that are valid and not yet done.
ctrl_read_pos  output  table_entries_ptrwidth  table read index.
ctrl_read_req  input  `DMA_REQUEST_WIDTH  request word at ctrl_read_pos; combinational, same cycle.
ctrl_done_pos  output  table_entries_ptrwidth  index of the finished entry.
ctrl_done_en  output  1  one-cycle done strobe to the table.
out_req  output  `DMA_REQUEST_WIDTH  registered request presented to the initiator.
out_id  output  table_entries_ptrwidth  table index of out_req.
out_req_valid  output  1  out_req is valid.
out_req_ready  input  1  initiator accepts out_req.
cpl_valid  input  1  one-cycle pulse: the accepted transfer has finished.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rr_ptr=0.
  - ctrl_read_pos=0, ctrl_done_pos=0, ctrl_done_en=0.
  - out_req=0, out_id=0, out_req_valid=0, busy=0.
- Reset mid-transfer aborts the transfer. No ctrl_done_en is issued, and the table entry stays valid.
- States: IDLE, LOAD, ISSUE, WAIT, DONE. All outputs are registered or decoded from state.
- IDLE:
  - Leaves only when enable=1 and valid is non-zero.
  - Selection: the first set bit of valid searched upward from rr_ptr, wrapping from table_entries-1 to 0.
  - On leaving: ctrl_read_pos<=sel, out_id<=sel, next state LOAD.
- LOAD: out_req<=ctrl_read_req; next state ISSUE.
- ISSUE:
  - out_req_valid=1. out_req and out_id are held stable until the handshake.
  - On out_req_ready=1, the handshake completes that edge.
  - Next state is WAIT, or DONE if cpl_valid=1 in the same cycle.
- WAIT: on cpl_valid=1, go to DONE. cpl_valid in any state other than ISSUE or WAIT is ignored.
- DONE:
  - ctrl_done_en=1 and ctrl_done_pos=out_id for exactly one cycle.
  - rr_ptr<=out_id+1, modulo table_entries.
  - Next state IDLE.
  - The table registers done at this edge, so the entry's valid bit is already 0 on the first cycle back in IDLE. The same entry is never re-dispatched.
- Latency: IDLE select cycle to out_req_valid is 2 cycles. cpl_valid to ctrl_done_en is 1 cycle.
- Minimum per-transfer cost: 4 cycles (IDLE, LOAD, ISSUE, DONE) when ready and cpl arrive in the ISSUE cycle.
- valid[out_id] falling while the transfer is in flight (software invalidation) has no effect; the transfer completes and done is still reported.
- Deasserting enable during LOAD, ISSUE, WAIT or DONE does not abort the transfer. Only the IDLE exit is gated.
- Fairness: with all entries continuously valid, service order is 0,1,2,3,0,...

Test Plan:
- Reset, then valid=4'b0100, enable=1, ready=1 tied, table word at pos 2 = 0xA5... → ctrl_read_pos=2 one cycle after the IDLE select. out_req_valid rises 2 cycles after select with out_req=table[2] and out_id=2. A cpl_valid pulse 3 cycles later → ctrl_done_en=1 with ctrl_done_pos=2 for one cycle, then busy=0.
- valid=4'b1111 held, instant ready and cpl → dispatch order out_id=0,1,2,3,0 with exactly 4 cycles between successive ctrl_done_en pulses.
- out_req_ready held low 5 cycles in ISSUE while ctrl_read_req changes → out_req and out_id are stable throughout. The handshake happens on the cycle ready=1.
- enable=0 with valid=4'b0011 → stays IDLE with busy=0. Dropping enable while in WAIT → the transfer still completes with ctrl_done_en, then no new dispatch.
- Assert rst=0 asynchronously (mid-cycle) while in WAIT for entry 1 → all outputs clear immediately with no ctrl_done_en. After release, entry 1 is dispatched again.
- cpl_valid pulsed while IDLE, and valid[out_id] dropped during WAIT → the IDLE pulse is ignored. The in-flight entry still gets ctrl_done_en with the correct ctrl_done_pos.
